// File: rtl/sp_ram_burst_pkg.sv
// rtl/sp_ram_burst_pkg.sv - shared types and constants for the SP-RAM burst master
// Purpose: burst master FSM state type and word-size helpers.
// Ports: none (package).
package sp_ram_burst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Bytes per word at the default 32-bit data width.
  localparam int BYTES_PER_WORD = 4;

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/sp_ram_rsp_fifo.sv
// rtl/sp_ram_rsp_fifo.sv - two-entry response FIFO for RAM read data
// Purpose: buffers RAM read data so the read stream can stall without loss.
// Ports: clk, rst_n (async, active-low); push_i/push_data_i write side;
//        pop_i/head_o read side (head_o is the oldest entry); full_o, empty_o.
module sp_ram_rsp_fifo #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic                  full_o,
  output logic                  empty_o
);

  logic [DATA_WIDTH-1:0] mem0_q, mem0_d;
  logic [DATA_WIDTH-1:0] mem1_q, mem1_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  do_push, do_pop;

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is legal then.
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = rd_ptr_q ? mem1_q : mem0_q;

  always_comb begin
    mem0_d   = mem0_q;
    mem1_d   = mem1_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      if (wr_ptr_q) mem1_d = push_data_i;
      else          mem0_d = push_data_i;
      wr_ptr_d = !wr_ptr_q;
    end
    if (do_pop) rd_ptr_d = !rd_ptr_q;
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0_q   <= '0;
      mem1_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem0_q   <= mem0_d;
      mem1_q   <= mem1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sp_ram_burst_master.sv
// rtl/sp_ram_burst_master.sv - burst read/write master for a single-port RAM
// Purpose: turns one command (direction, start address, beat count) into a
//          burst of word accesses on a single-port RAM with 1-cycle read latency.
// Ports: clk, rst_n (async, active-low);
//        cmd_*   : command handshake (valid/ready, write, addr, len);
//        wdata_* : write stream in (valid/ready, data, byte enables);
//        rdata_* : read stream out (valid/ready, data);
//        ram_*   : RAM port (en, we, addr, wdata, be, rdata);
//        busy_o  : burst in progress; done_o : one-cycle pulse at burst end.
module sp_ram_burst_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]    cmd_len_i,
  input  logic                    wdata_valid_i,
  output logic                    wdata_ready_o,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wbe_i,
  output logic                    rdata_valid_o,
  input  logic                    rdata_ready_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    ram_en_o,
  output logic                    ram_we_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
  output logic                    busy_o,
  output logic                    done_o
);

  import sp_ram_burst_pkg::*;

  localparam int BYTES = bytes_per_word(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  remain_q, remain_d;
  logic                  inflight_q, inflight_d;
  logic                  done_q, done_d;

  logic       fifo_full, fifo_empty, fifo_pop;
  logic [1:0] fifo_occ, occ_after_pop;
  logic       can_issue;

  assign fifo_pop      = !fifo_empty && rdata_ready_i;
  assign rdata_valid_o = !fifo_empty;
  assign fifo_occ      = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  // Counting this cycle's pop lets a new read issue every cycle while the
  // consumer keeps up, yet never more than two words are owed to the FIFO.
  assign occ_after_pop = fifo_occ - {1'b0, fifo_pop};
  assign can_issue     = (occ_after_pop + {1'b0, inflight_q}) < 2'd2;
  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = done_q;

  sp_ram_rsp_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_rsp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (inflight_q),
    .push_data_i (ram_rdata_i),
    .pop_i       (fifo_pop),
    .head_o      (rdata_o),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remain_d      = remain_q;
    inflight_d    = 1'b0;
    done_d        = 1'b0;
    cmd_ready_o   = 1'b0;
    wdata_ready_o = 1'b0;
    ram_en_o      = 1'b0;
    ram_we_o      = 1'b0;
    ram_addr_o    = addr_q;
    ram_wdata_o   = '0;
    ram_be_o      = '0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          addr_d   = cmd_addr_i & ALIGN_MASK;
          remain_d = cmd_len_i;
          if (cmd_len_i == '0) done_d  = 1'b1;
          else if (cmd_write_i) state_d = ST_WRITE;
          else                  state_d = ST_READ;
        end
      end
      ST_WRITE: begin
        wdata_ready_o = 1'b1;
        if (wdata_valid_i) begin
          ram_en_o    = 1'b1;
          ram_we_o    = 1'b1;
          ram_wdata_o = wdata_i;
          ram_be_o    = wbe_i;
          addr_d      = addr_q + STEP;
          remain_d    = remain_q - LEN_WIDTH'(1);
          if (remain_q == LEN_WIDTH'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (can_issue) begin
          ram_en_o   = 1'b1;
          inflight_d = 1'b1;
          addr_d     = addr_q + STEP;
          remain_d   = remain_q - LEN_WIDTH'(1);
          if (remain_q == LEN_WIDTH'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!inflight_q && occ_after_pop == 2'd0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_sp_ram_burst_master.sv
// tb/tb_sp_ram_burst_master.sv - self-checking bench for sp_ram_burst_master
module tb_sp_ram_burst_master;
  import sp_ram_burst_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid_i = 1'b0, cmd_write_i = 1'b0;
  logic [AW-1:0] cmd_addr_i = '0;
  logic [LW-1:0] cmd_len_i = '0;
  logic          cmd_ready_o;
  logic          wdata_valid_i = 1'b0, wdata_ready_o;
  logic [DW-1:0] wdata_i = '0;
  logic [3:0]    wbe_i = '0;
  logic          rdata_valid_o, rdata_ready_i = 1'b0;
  logic [DW-1:0] rdata_o;
  logic          ram_en_o, ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_wdata_o, ram_rdata_i;
  logic [3:0]    ram_be_o;
  logic          busy_o, done_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ram_mem [64];
  logic [31:0] ref_mem [64];
  bit          mem_init = 1'b0;

  always #5 clk = ~clk;

  sp_ram_burst_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata_i), .wbe_i(wbe_i),
    .rdata_valid_o(rdata_valid_o), .rdata_ready_i(rdata_ready_i), .rdata_o(rdata_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_be_o(ram_be_o), .ram_rdata_i(ram_rdata_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'h5A000000 + 32'(i) * 32'h00010101;
  endfunction

  // Single-port RAM: byte-enabled writes, read data one cycle after enable.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) ram_mem[i] <= init_word(i);
      mem_init <= 1'b1;
    end else if (ram_en_o) begin
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (ram_be_o[b]) ram_mem[ram_addr_o[7:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      end else begin
        ram_rdata_i <= ram_mem[ram_addr_o[7:2]];
      end
    end
  end

  function automatic int next_addr(input int a);
    return (a + BYTES_PER_WORD) % 256;
  endfunction

  // Presents a command at the current negedge; returns at the next negedge
  // (first cycle after the accepting edge).
  task automatic send_cmd(input bit wr, input int addr, input int len);
    cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = AW'(addr); cmd_len_i = LW'(len);
    #1;
    n_checks++;
    if (cmd_ready_o !== 1'b1 || ram_en_o !== 1'b0) begin
      n_fail++; $display("FAIL cmd_accept: ready=%b ram_en=%b want ready=1 ram_en=0", cmd_ready_o, ram_en_o);
    end
    @(negedge clk);
    cmd_valid_i = 1'b0;
  endtask

  task automatic run_write(input int addr, input int len, input bit gaps, input bit rand_data,
                           input logic [31:0] data0, input logic [3:0] be);
    int beats = 0, cycles = 0, exp_addr;
    logic [31:0] d;
    logic [3:0]  b;
    exp_addr = addr - (addr % BYTES_PER_WORD);
    send_cmd(1'b1, addr, len);
    while (beats < len && cycles < 200) begin
      d = rand_data ? $urandom : data0 + 32'(beats);
      b = rand_data ? 4'($urandom_range(0, 15)) : be;
      wdata_valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      wdata_i = d; wbe_i = b;
      #1;
      n_checks++;
      if (wdata_ready_o !== 1'b1 || busy_o !== 1'b1 || done_o !== 1'b0) begin
        n_fail++; $display("FAIL write_status: wready=%b busy=%b done=%b want 1 1 0", wdata_ready_o, busy_o, done_o);
      end
      n_checks++;
      if (wdata_valid_i) begin
        if ({ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_be_o} !== {2'b11, AW'(exp_addr), d, b}) begin
          n_fail++;
          $display("FAIL write_beat %0d: en=%b we=%b addr=%h data=%h be=%h want 1 1 %h %h %h",
                   beats, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_be_o, AW'(exp_addr), d, b);
        end
        for (int k = 0; k < 4; k++) if (b[k]) ref_mem[exp_addr / 4][8*k +: 8] = d[8*k +: 8];
        exp_addr = next_addr(exp_addr);
        beats++;
      end else if (ram_en_o !== 1'b0 || ram_we_o !== 1'b0) begin
        n_fail++; $display("FAIL write_idle_beat: en=%b we=%b want 0 0", ram_en_o, ram_we_o);
      end
      cycles++;
      @(negedge clk);
    end
    wdata_valid_i = 1'b0;
    n_checks++;
    if (beats != len) begin
      n_fail++; $display("FAIL write_timeout: beats=%0d want %0d", beats, len);
    end
    if (!gaps) begin
      n_checks++;
      if (cycles != len) begin
        n_fail++; $display("FAIL write_consecutive: cycles=%0d want %0d", cycles, len);
      end
    end
    #1;
    n_checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || ram_en_o !== 1'b0 || wdata_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL write_done: done=%b busy=%b en=%b wready=%b want 1 0 0 0", done_o, busy_o, ram_en_o, wdata_ready_o);
    end
    @(negedge clk); #1;
    n_checks++;
    if (done_o !== 1'b0) begin
      n_fail++; $display("FAIL write_done_pulse: done=%b want 0", done_o);
    end
    @(negedge clk);
  endtask

  // mode 0: ready held 1; 1: ready toggles; 2: ready random.
  // abort_after > 0 returns early once that many words have been taken.
  task automatic run_read(input int addr, input int len, input int mode, input int abort_after);
    int  issued = 0, popped = 0, cycles = 1, iss_addr, pop_addr;
    bit  pop_now;
    iss_addr = addr - (addr % BYTES_PER_WORD);
    pop_addr = iss_addr;
    send_cmd(1'b0, addr, len);
    while (popped < len && cycles < 300) begin
      case (mode)
        0:       rdata_ready_i = 1'b1;
        1:       rdata_ready_i = cycles[0];
        default: rdata_ready_i = 1'($urandom_range(0, 1));
      endcase
      #1;
      pop_now = rdata_valid_o && rdata_ready_i;
      if (ram_en_o) begin
        n_checks++;
        if (ram_we_o !== 1'b0 || ram_be_o !== 4'h0 || ram_addr_o !== AW'(iss_addr) || issued >= len) begin
          n_fail++;
          $display("FAIL read_issue %0d: we=%b be=%h addr=%h want 0 0 %h (len %0d)", issued, ram_we_o, ram_be_o, ram_addr_o, AW'(iss_addr), len);
        end
        n_checks++;
        if (issued - popped - int'(pop_now) >= 2) begin
          n_fail++; $display("FAIL read_overcommit: outstanding=%0d want <2", issued - popped - int'(pop_now));
        end
        issued++;
        iss_addr = next_addr(iss_addr);
      end
      if (mode == 0) begin
        // Data rises on the second edge after the accepting edge, then streams.
        n_checks++;
        if (rdata_valid_o !== 1'(cycles >= 3)) begin
          n_fail++; $display("FAIL read_valid_timing cycle %0d: valid=%b want %b", cycles, rdata_valid_o, 1'(cycles >= 3));
        end
      end
      if (pop_now) begin
        n_checks++;
        if (rdata_o !== ref_mem[pop_addr / 4]) begin
          n_fail++; $display("FAIL read_data %0d: got %h want %h", popped, rdata_o, ref_mem[pop_addr / 4]);
        end
        popped++;
        pop_addr = next_addr(pop_addr);
      end
      n_checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b1 || wdata_ready_o !== 1'b0) begin
        n_fail++; $display("FAIL read_status: done=%b busy=%b wready=%b want 0 1 0", done_o, busy_o, wdata_ready_o);
      end
      cycles++;
      @(negedge clk);
      if (abort_after > 0 && popped == abort_after) return;
    end
    rdata_ready_i = 1'b0;
    n_checks++;
    if (popped != len) begin
      n_fail++; $display("FAIL read_timeout: words=%0d want %0d", popped, len);
    end
    if (mode == 0) begin
      n_checks++;
      if (cycles != len + 3) begin
        n_fail++; $display("FAIL read_throughput: cycles=%0d want %0d", cycles, len + 3);
      end
    end
    #1;
    n_checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || rdata_valid_o !== 1'b0 || ram_en_o !== 1'b0) begin
      n_fail++; $display("FAIL read_done: done=%b busy=%b valid=%b en=%b want 1 0 0 0", done_o, busy_o, rdata_valid_o, ram_en_o);
    end
    @(negedge clk); #1;
    n_checks++;
    if (done_o !== 1'b0) begin
      n_fail++; $display("FAIL read_done_pulse: done=%b want 0", done_o);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({ram_en_o, ram_we_o, rdata_valid_o, wdata_ready_o, done_o, busy_o} !== 6'b0) begin
      n_fail++; $display("FAIL reset_outputs: en=%b we=%b rvalid=%b wready=%b done=%b busy=%b want all 0",
                         ram_en_o, ram_we_o, rdata_valid_o, wdata_ready_o, done_o, busy_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: cmd_ready=%b busy=%b want 1 0", cmd_ready_o, busy_o);
    end
    @(negedge clk);
  endtask

  task automatic test_write_burst();
    run_write(32'h10, 4, 1'b0, 1'b0, 32'hA0, 4'hF);
  endtask

  task automatic test_read_burst();
    run_read(32'h10, 4, 0, 0);
  endtask

  task automatic test_read_backpressure();
    run_read(32'h10, 6, 1, 0);
  endtask

  task automatic test_wrap_align();
    run_write(32'hFC, 2, 1'b0, 1'b0, 32'hB0, 4'hF);
    run_write(32'h13, 1, 1'b0, 1'b0, 32'hC0, 4'hF);
    run_read(32'hFC, 2, 2, 0);
    run_read(32'h12, 1, 0, 0);
  endtask

  task automatic test_byte_enable();
    int cycles = 0;
    bit got = 1'b0;
    run_write(32'h40, 1, 1'b0, 1'b0, 32'hFFFFFFFF, 4'hF);
    run_write(32'h40, 1, 1'b0, 1'b0, 32'h12345678, 4'h3);
    send_cmd(1'b0, 32'h40, 1);
    rdata_ready_i = 1'b1;
    while (!got && cycles < 20) begin
      #1;
      if (rdata_valid_o) begin
        got = 1'b1;
        n_checks++;
        if (rdata_o !== 32'hFFFF5678) begin
          n_fail++; $display("FAIL byte_enable_readback: got %h want ffff5678", rdata_o);
        end
      end
      cycles++;
      @(negedge clk);
    end
    rdata_ready_i = 1'b0;
    n_checks++;
    if (!got) begin
      n_fail++; $display("FAIL byte_enable_timeout: no read data within %0d cycles", cycles);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_len_zero();
    for (int w = 0; w < 2; w++) begin
      send_cmd(1'(w), 32'h20, 0);
      #1;
      n_checks++;
      if (done_o !== 1'b1 || ram_en_o !== 1'b0 || busy_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
        n_fail++; $display("FAIL len_zero dir=%0d: done=%b en=%b busy=%b ready=%b want 1 0 0 1", w, done_o, ram_en_o, busy_o, cmd_ready_o);
      end
      @(negedge clk); #1;
      n_checks++;
      if (done_o !== 1'b0 || ram_en_o !== 1'b0) begin
        n_fail++; $display("FAIL len_zero_after dir=%0d: done=%b en=%b want 0 0", w, done_o, ram_en_o);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_read();
    run_read(32'h10, 4, 0, 2);
    rst_n = 1'b0;
    rdata_ready_i = 1'b0;
    #1;
    n_checks++;
    if (rdata_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || ram_en_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_read: valid=%b busy=%b done=%b en=%b want 0 0 0 0", rdata_valid_o, busy_o, done_o, ram_en_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++;
      if (ram_en_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0 || rdata_valid_o !== 1'b0) begin
        n_fail++; $display("FAIL post_reset_quiet %0d: en=%b done=%b busy=%b valid=%b want 0", i, ram_en_o, done_o, busy_o, rdata_valid_o);
      end
      @(negedge clk);
    end
    run_read(32'h10, 4, 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 1) == 1)
        run_write(int'($urandom_range(0, 255)), int'($urandom_range(1, 8)), 1'($urandom_range(0, 1)), 1'b1, 32'h0, 4'h0);
      else
        run_read(int'($urandom_range(0, 255)), int'($urandom_range(1, 8)), int'($urandom_range(0, 2)), 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    test_reset();
    test_write_burst();
    test_read_burst();
    test_read_backpressure();
    test_wrap_align();
    test_byte_enable();
    test_len_zero();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sp_ram_burst_master.md
SP_RAM_BURST_MASTER -- requirements
Module: sp_ram_burst_master

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 8, byte-address width of RAM port; DATA_WIDTH, default 32, word width (multiple of 8); LEN_WIDTH, default 8, burst-length width.
REQ-002 SHALL have ports, in this order: clk  in  1  sole clock, rising edge; rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have command ports: cmd_valid_i in 1; cmd_ready_o out 1; cmd_write_i in 1 (1=write burst, 0=read burst); cmd_addr_i in ADDR_WIDTH (start byte address); cmd_len_i in LEN_WIDTH (beat count).
REQ-004 SHALL have write-stream ports: wdata_valid_i in 1; wdata_ready_o out 1; wdata_i in DATA_WIDTH; wbe_i in DATA_WIDTH/8.
REQ-005 SHALL have read-stream ports: rdata_valid_o out 1; rdata_ready_i in 1; rdata_o out DATA_WIDTH.
REQ-006 SHALL have RAM-side ports: ram_en_o out 1; ram_we_o out 1; ram_addr_o out ADDR_WIDTH; ram_wdata_o out DATA_WIDTH; ram_be_o out DATA_WIDTH/8; ram_rdata_i in DATA_WIDTH (valid one cycle after a read enable).
REQ-007 SHALL have status ports: busy_o out 1 (state not IDLE); done_o out 1 (one-cycle pulse at burst end).

Function
REQ-008 SHALL implement states IDLE, WRITE, READ, DRAIN.
REQ-009 cmd_ready_o SHALL be 1 only in IDLE; handshake on cmd_valid_i&&cmd_ready_o latches addr (low log2(DATA_WIDTH/8) bits forced 0), len, direction.
REQ-010 Accepted cmd with len=0 SHALL stay in IDLE, issue no RAM access, and pulse done_o next cycle.
REQ-011 IDLE->WRITE on accepted write cmd (len>0); IDLE->READ on accepted read cmd (len>0).
REQ-012 In WRITE, wdata_ready_o SHALL equal 1; each wdata handshake SHALL drive ram_en_o=1, ram_we_o=1, ram_addr_o=current addr, ram_wdata_o=wdata_i, ram_be_o=wbe_i combinationally in that same cycle.
REQ-013 Outside WRITE, wdata_ready_o SHALL be 0; ram_we_o SHALL be 0 whenever ram_en_o=0.
REQ-014 Each issued beat SHALL advance address by DATA_WIDTH/8, wrapping modulo 2^ADDR_WIDTH, and decrement remaining count.
REQ-015 WRITE->IDLE with done_o pulse the cycle after the last beat's handshake.
REQ-016 In READ, a read SHALL issue (ram_en_o=1, ram_we_o=0, ram_be_o all 0) only when FIFO occupancy + reads in flight < 2.
REQ-017 ram_rdata_i SHALL be pushed into a 2-entry response FIFO exactly one cycle after each read issue; no data SHALL be dropped under any rdata_ready_i pattern.
REQ-018 rdata_valid_o SHALL equal FIFO non-empty; rdata_o SHALL be the FIFO head; pop on rdata_valid_o&&rdata_ready_i; simultaneous push and pop SHALL be allowed at occupancy 1 or 2.
REQ-019 READ->DRAIN after last read issues; DRAIN->IDLE with done_o pulse when nothing in flight and FIFO empty after pop.
REQ-020 Sustained throughput SHALL be one beat per cycle with rdata_ready_i held 1.

Reset
REQ-021 On rst_n low: state IDLE, FIFO empty, in-flight flag 0, counters 0; outputs cmd_ready_o=1 after release, ram_en_o=0, ram_we_o=0, rdata_valid_o=0, wdata_ready_o=0, done_o=0, busy_o=0.
REQ-022 Reset mid-burst SHALL abort immediately; no RAM access and no done_o pulse after deassertion until a new command.

Structure
REQ-023 Package sp_ram_burst_pkg SHALL hold the state enum type and BYTES_PER_WORD helper constant.
REQ-024 Response FIFO SHALL be sub-module sp_ram_rsp_fifo (2 entries, DATA_WIDTH parameter, push/pop/full/empty).

Verification
REQ-025 Write cmd addr=0x10 len=4, wdata 0xA0..0xA3 all be=0xF, valid continuous -> ram writes at 0x10,0x14,0x18,0x1C on 4 consecutive cycles, done_o 1 cycle later.
REQ-026 Read cmd addr=0x10 len=4, rdata_ready_i=1 -> rdata_o 0xA0..0xA3 in order, first valid 2 cycles after cmd accept, back-to-back.
REQ-027 Read len=6 with rdata_ready_i toggling 1/0 every cycle -> all 6 words delivered in order, ram_en_o never issues when FIFO+inflight=2.
REQ-028 Write addr=0xFC len=2 (ADDR_WIDTH=8) -> accesses at 0xFC then 0x00; cmd_addr_i=0x13 -> first access 0x10.
REQ-029 Write with wbe_i=0x3 over word 0xFFFFFFFF, data 0x12345678 -> readback 0xFFFF5678; len=0 cmd -> no ram_en_o, done_o pulse.
REQ-030 rst_n asserted mid-read (after 2 of 4 beats) -> rdata_valid_o=0, busy_o=0, no done_o; next read cmd completes normally.
